// File: rtl/label_table_sched.sv
// rtl/label_table_sched.sv - shares the single-port label-acceptance table between Rx lookups, host writes and a clear sweep
module label_table_sched #(
  parameter int NUM_CH  = 4,
  parameter int LABEL_W = 8,
  parameter int CH_W    = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [NUM_CH-1:0]          Req_valid,
  input  logic [NUM_CH*LABEL_W-1:0]  Req_label,
  output logic [NUM_CH-1:0]          Req_ack,
  output logic [NUM_CH-1:0]          Resp_valid,
  output logic [NUM_CH-1:0]          Resp_hit,
  input  logic                       Cfg_wr,
  input  logic [LABEL_W-1:0]         Cfg_adr,
  input  logic                       Cfg_en,
  input  logic                       Cfg_clear,
  output logic                       Cfg_busy,
  output logic                       Cfg_err,
  output logic                       Clear_done,
  output logic                       Tbl_wr,
  output logic                       Tbl_rd,
  output logic [LABEL_W-1:0]         Tbl_adr,
  output logic                       Tbl_din,
  input  logic                       Tbl_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [LABEL_W-1:0]  cnt, cnt_nxt;
  logic [CH_W-1:0]     rr;
  logic [CH_W-1:0]     grant_ch;
  logic                grant_found;
  logic                grant;
  logic                sweep_last;
  logic                p_valid;
  logic [CH_W-1:0]     p_ch;
  logic [NUM_CH-1:0]   p_onehot;
  logic                err_q;
  logic                done_q;
  logic [NUM_CH-1:0]   resp_valid_q;
  logic [NUM_CH-1:0]   resp_hit_q;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!grant_found && Req_valid[CH_W'((int'(rr) + k) % NUM_CH)]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'((int'(rr) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    Tbl_wr     = 1'b0;
    Tbl_rd     = 1'b0;
    Tbl_adr    = '0;
    Tbl_din    = 1'b0;
    Req_ack    = '0;
    grant      = 1'b0;
    sweep_last = 1'b0;
    // While Rst is high no table access may slip out (the aborted sweep write included).
    if (!Rst) begin
      case (state)
        IDLE: begin
          if (Cfg_clear) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
          end else if (Cfg_wr) begin
            Tbl_wr  = 1'b1;
            Tbl_adr = Cfg_adr;
            Tbl_din = Cfg_en;
          end else if (grant_found) begin
            grant             = 1'b1;
            Req_ack[grant_ch] = 1'b1;
            Tbl_rd            = 1'b1;
            Tbl_adr           = Req_label[int'(grant_ch)*LABEL_W +: LABEL_W];
          end
        end
        CLEAR: begin
          Tbl_wr  = 1'b1;
          Tbl_adr = cnt;
          Tbl_din = 1'b0;
          cnt_nxt = cnt + LABEL_W'(1);
          if (cnt == '1) begin
            state_nxt  = IDLE;
            sweep_last = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign p_onehot = NUM_CH'(1) << p_ch;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rr           <= CH_W'(NUM_CH - 1);
      p_valid      <= 1'b0;
      p_ch         <= '0;
      resp_valid_q <= '0;
      resp_hit_q   <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (grant) rr <= grant_ch;
      p_valid <= grant;
      p_ch    <= grant_ch;
      // Tbl_dout is valid the cycle after the read; register it into the response.
      resp_valid_q <= p_valid ? p_onehot : '0;
      resp_hit_q   <= (p_valid && Tbl_dout) ? p_onehot : '0;
      err_q        <= Cfg_wr && ((state == CLEAR) || Cfg_clear);
      done_q       <= sweep_last;
    end
  end

  assign Resp_valid = resp_valid_q;
  assign Resp_hit   = resp_hit_q;
  assign Cfg_busy   = (state == CLEAR);
  assign Cfg_err    = err_q;
  assign Clear_done = done_q;

endmodule

// File: tb/tb_label_table_sched.sv
// tb/tb_label_table_sched.sv - scoreboard bench for label_table_sched with a behavioural 256x1 table
module tb_label_table_sched;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  Req_valid;
  logic [31:0] Req_label;
  logic [3:0]  Req_ack, Resp_valid, Resp_hit;
  logic        Cfg_wr, Cfg_en, Cfg_clear;
  logic [7:0]  Cfg_adr;
  logic        Cfg_busy, Cfg_err, Clear_done;
  logic        Tbl_wr, Tbl_rd, Tbl_din, Tbl_dout;
  logic [7:0]  Tbl_adr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int due; int ch; logic hit; } exp_t;
  exp_t exp_q[$];

  logic mem [256];
  logic ref_tbl [256];

  always #5 Clk = ~Clk;

  label_table_sched #(.NUM_CH(4), .LABEL_W(8), .CH_W(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req_valid(Req_valid), .Req_label(Req_label), .Req_ack(Req_ack),
    .Resp_valid(Resp_valid), .Resp_hit(Resp_hit),
    .Cfg_wr(Cfg_wr), .Cfg_adr(Cfg_adr), .Cfg_en(Cfg_en), .Cfg_clear(Cfg_clear),
    .Cfg_busy(Cfg_busy), .Cfg_err(Cfg_err), .Clear_done(Clear_done),
    .Tbl_wr(Tbl_wr), .Tbl_rd(Tbl_rd), .Tbl_adr(Tbl_adr), .Tbl_din(Tbl_din),
    .Tbl_dout(Tbl_dout)
  );

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Tbl_wr) mem[Tbl_adr] <= Tbl_din;
    if (Tbl_rd) Tbl_dout <= mem[Tbl_adr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected hit comes from the bench's own view of the table.
  always @(negedge Clk) begin
    if (!Rst) begin
      check("tbl_excl", {31'b0, Tbl_wr & Tbl_rd}, 32'd0);
      for (int ch = 0; ch < 4; ch++)
        if (Req_ack[ch]) exp_q.push_back('{cyc + 2, ch, ref_tbl[Req_label[ch*8 +: 8]]});
      if (Resp_valid != 4'b0) begin
        if (exp_q.size() == 0) check("resp_unexpected", {28'b0, Resp_valid}, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_ch", {28'b0, Resp_valid}, 32'd1 << e.ch);
          check("resp_hit", {28'b0, Resp_hit}, e.hit ? (32'd1 << e.ch) : 32'd0);
          check("resp_lat", cyc, e.due);
        end
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] adr, input logic en);
    Cfg_wr = 1'b1; Cfg_adr = adr; Cfg_en = en;
    ref_tbl[adr] = en;
    tick();
    Cfg_wr = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [7:0] label);
    Req_valid[ch] = 1'b1;
    Req_label[ch*8 +: 8] = label;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic lookup(input int ch, input logic [7:0] label);
    logic got;
    got = 1'b0;
    set_req(ch, label);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge Clk);
      got = Req_ack[ch];
      tick();
    end
    Req_valid[ch] = 1'b0;
    check("lookup_ack", {31'b0, got}, 32'd1);
    drain();
  endtask

  task automatic do_reset;
    Rst = 1'b1; Req_valid = '0; Cfg_wr = 1'b0; Cfg_clear = 1'b0;
    tick(); tick();
    exp_q.delete();
    Rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt;
    for (int a = 0; a < 256; a++) begin mem[a] = 1'b0; ref_tbl[a] = 1'b0; end
    Tbl_dout = 1'b0;
    Rst = 1'b1; Req_valid = '0; Req_label = '0;
    Cfg_wr = 1'b0; Cfg_adr = '0; Cfg_en = 1'b0; Cfg_clear = 1'b0;
    tick(); tick();
    @(negedge Clk);
    check("rst_outputs", {Req_ack, Resp_valid, Resp_hit, Cfg_busy, Cfg_err, Clear_done, Tbl_wr, Tbl_rd}, 32'd0);
    tick();
    Rst = 1'b0;

    // Host write then lookup of the same label next cycle.
    Cfg_wr = 1'b1; Cfg_adr = 8'h0A; Cfg_en = 1'b1; ref_tbl[8'h0A] = 1'b1;
    @(negedge Clk);
    check("wr_pass", {Tbl_wr, Tbl_adr, Tbl_din}, {1'b1, 8'h0A, 1'b1});
    tick();
    Cfg_wr = 1'b0;
    set_req(0, 8'h0A);
    @(negedge Clk);
    check("t1_ack", {28'b0, Req_ack}, 32'h1);
    check("t1_rd", {Tbl_rd, Tbl_adr}, {1'b1, 8'h0A});
    tick();
    Req_valid = '0;
    drain();

    // Continuous requests from all channels after reset: strict rotation.
    cfg_write(8'h33, 1'b1);
    do_reset();
    set_req(0, 8'h0A); set_req(1, 8'h11); set_req(2, 8'h22); set_req(3, 8'h33);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("rr_grant", {28'b0, Req_ack}, 32'd1 << (i % 4));
      tick();
    end
    Req_valid = '0;
    drain();

    // Host write and ch2 request together: write first, ch2 the next cycle.
    Cfg_wr = 1'b1; Cfg_adr = 8'h22; Cfg_en = 1'b1; ref_tbl[8'h22] = 1'b1;
    set_req(2, 8'h22);
    @(negedge Clk);
    check("t3_stall", {Req_ack, Tbl_wr, Tbl_rd}, {4'b0, 1'b1, 1'b0});
    tick();
    Cfg_wr = 1'b0;
    @(negedge Clk);
    check("t3_ack", {Req_ack, Tbl_rd, Tbl_adr}, {4'b0100, 1'b1, 8'h22});
    tick();
    Req_valid = '0;
    drain();

    // Clear sweep with a dropped write, ignored re-clear, and a lookup waiting on it.
    cfg_write(8'h05, 1'b1);
    cfg_write(8'hFF, 1'b1);
    Cfg_clear = 1'b1;
    for (int a = 0; a < 256; a++) ref_tbl[a] = 1'b0;
    @(negedge Clk);
    check("clr_start_noop", {Tbl_wr, Tbl_rd, Cfg_busy}, 3'b000);
    tick();
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      Cfg_clear = (c == 50);
      Cfg_wr = (c == 10); Cfg_adr = 8'h05; Cfg_en = 1'b1;
      if (c == 3) set_req(1, 8'h05);
      if (c == 257) Req_valid = '0;
      @(negedge Clk);
      if (Cfg_busy) busy_cnt++;
      if (c == 10) check("sweep_adr", {Tbl_wr, Tbl_adr, Tbl_din}, {1'b1, 8'd10, 1'b0});
      if (c == 11) check("clr_err", {31'b0, Cfg_err}, 32'd1);
      if (c == 100 || c == 255) check("no_ack_in_clear", {28'b0, Req_ack}, 32'd0);
      if (Clear_done) begin
        done_cnt++;
        check("done_cycle", c, 32'd256);
        check("ack_after_clear", {28'b0, Req_ack}, 32'h2);
      end
      tick();
    end
    Cfg_clear = 1'b0; Cfg_wr = 1'b0;
    check("busy_cycles", busy_cnt, 32'd256);
    check("done_count", done_cnt, 32'd1);
    drain();
    lookup(3, 8'hFF);

    // Reset in sweep cycle 100 leaves entries >= 100 untouched.
    cfg_write(8'h63, 1'b1);
    cfg_write(8'h64, 1'b1);
    cfg_write(8'h80, 1'b1);
    cfg_write(8'hC8, 1'b1);
    Cfg_clear = 1'b1; Cfg_wr = 1'b1; Cfg_adr = 8'hC9; Cfg_en = 1'b1;
    for (int a = 0; a < 100; a++) ref_tbl[a] = 1'b0;
    tick();
    Cfg_clear = 1'b0; Cfg_wr = 1'b0;
    @(negedge Clk);
    check("clr_wr_err", {Cfg_err, Cfg_busy}, 2'b11);
    repeat (100) tick();
    Rst = 1'b1;
    @(negedge Clk);
    check("rst_no_write", {31'b0, Tbl_wr}, 32'd0);
    tick();
    Rst = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clk);
      if (Cfg_busy) busy_cnt++;
      if (Clear_done) done_cnt++;
      tick();
    end
    check("abort_busy", busy_cnt, 32'd0);
    check("abort_done", done_cnt, 32'd0);
    lookup(0, 8'h63);
    lookup(1, 8'h64);
    lookup(2, 8'h80);
    lookup(3, 8'hC8);
    lookup(0, 8'hC9);
    lookup(1, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
